// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares a single-port word-addressed instruction memory
// between the fetch stage and the program loader. Round-robin on contention,
// boot-hold blocks fetch, byte addresses are converted to word indices, and
// misaligned / out-of-range accesses are granted but never touch memory.
// Optional build macro: IMEM_ARB_STATS_EN enables the saturating fetch-stall
// counter on stall_cnt_o; otherwise stall_cnt_o is tied to zero.
module imem_port_arbiter #(
  parameter int          DEPTH    = 256,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013,
  localparam int         AW       = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          boot_hold_i,
  input  logic          fetch_req_i,
  input  logic [31:0]   fetch_addr_i,
  output logic          fetch_gnt_o,
  output logic          fetch_rvalid_o,
  output logic [31:0]   fetch_rdata_o,
  output logic          fetch_err_o,
  input  logic          load_req_i,
  input  logic [31:0]   load_addr_i,
  input  logic [31:0]   load_wdata_i,
  output logic          load_gnt_o,
  output logic          load_err_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i,
  output logic [15:0]   stall_cnt_o
);

  typedef enum logic {LAST_FETCH, LAST_LOAD} last_e;

  last_e last_q;
  logic  rd_pend_q, rd_pend_d;
  logic  ferr_q, ferr_d;
  logic  lerr_q, lerr_d;

  logic f_act, l_act, contested;
  logic f_legal, l_legal;

  // Legal = word aligned and inside the memory (no bits above the word index)
  assign f_legal = (fetch_addr_i[1:0] == 2'b00) && ((fetch_addr_i >> (AW + 2)) == 32'd0);
  assign l_legal = (load_addr_i[1:0]  == 2'b00) && ((load_addr_i  >> (AW + 2)) == 32'd0);

  // Arbitration is purely from requests and registered state; reset kills all grants
  always_comb begin
    f_act       = fetch_req_i & ~boot_hold_i & ~rst_i;
    l_act       = load_req_i & ~rst_i;
    contested   = f_act & l_act;
    fetch_gnt_o = f_act & (~l_act | (last_q == LAST_LOAD));
    load_gnt_o  = l_act & (~f_act | (last_q == LAST_FETCH));
    mem_en_o    = (fetch_gnt_o & f_legal) | (load_gnt_o & l_legal);
    mem_we_o    = load_gnt_o & l_legal;
    mem_addr_o  = load_gnt_o ? load_addr_i[AW+1:2] : fetch_addr_i[AW+1:2];
    mem_wdata_o = load_wdata_i;
    rd_pend_d   = fetch_gnt_o;
    ferr_d      = fetch_gnt_o & ~f_legal;
    lerr_d      = load_gnt_o & ~l_legal;
  end

  // Response/error flags and the round-robin pointer (moves only on contention)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_pend_q <= 1'b0;
      ferr_q    <= 1'b0;
      lerr_q    <= 1'b0;
      last_q    <= LAST_LOAD;
    end else begin
      rd_pend_q <= rd_pend_d;
      ferr_q    <= ferr_d;
      lerr_q    <= lerr_d;
      if (contested) last_q <= fetch_gnt_o ? LAST_FETCH : LAST_LOAD;
    end
  end

  // Reset in the response cycle cancels the delivery outright
  assign fetch_rvalid_o = rd_pend_q & ~rst_i;
  assign fetch_err_o    = ferr_q & fetch_rvalid_o;
  assign fetch_rdata_o  = !fetch_rvalid_o ? 32'd0 : (ferr_q ? NOP_INSN : mem_rdata_i);
  assign load_err_o     = lerr_q & ~rst_i;

`ifdef IMEM_ARB_STATS_EN
  logic [15:0] stall_q;

  // Saturating count of cycles the fetch stage waited for a grant
  always_ff @(posedge clk_i) begin
    if (rst_i) stall_q <= 16'd0;
    else if (fetch_req_i && !fetch_gnt_o && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Testbench for imem_port_arbiter: a behavioural RAM serves the DUT's memory
// port, a reference model predicts grants / memory controls / responses from
// the arbitration rules, and a separate monitor checks the fetch and load-error
// responses popped from a scoreboard queue.
module tb_imem_port_arbiter;
  localparam int          DEPTH = 256;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, boot_hold, fetch_req, load_req;
  logic [31:0] fetch_addr, load_addr, load_wdata;
  logic        fetch_gnt, fetch_rvalid, fetch_err, load_gnt, load_err;
  logic [31:0] fetch_rdata, mem_wdata, mem_rdata;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] stall_cnt;

  imem_port_arbiter #(.DEPTH(DEPTH), .NOP_INSN(NOP)) dut (
    .clk_i(clk), .rst_i(rst), .boot_hold_i(boot_hold),
    .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_gnt_o(fetch_gnt),
    .fetch_rvalid_o(fetch_rvalid), .fetch_rdata_o(fetch_rdata), .fetch_err_o(fetch_err),
    .load_req_i(load_req), .load_addr_i(load_addr), .load_wdata_i(load_wdata),
    .load_gnt_o(load_gnt), .load_err_o(load_err),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural single-port synchronous RAM driven by the DUT
  logic [31:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
  endtask

  // Reference model state
  typedef struct { logic err; logic [31:0] data; } rsp_t;
  rsp_t        fq [$];
  bit          lq [$];
  logic [31:0] ref_mem [DEPTH];
  bit          last_was_load = 1'b1;
  int          m_stall = 0;
  bit          fg_seen, lg_seen;

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a < 4 * DEPTH);
  endfunction

  // Model: who should win this cycle and what the memory port must show
  always @(negedge clk) begin
    bit ef, el, cf, cl, exp_en, exp_we;
    ef = 0; el = 0;
    if (!rst) begin
      cf = fetch_req && !boot_hold;
      cl = load_req;
      if (cf && cl) begin
        if (last_was_load) ef = 1; else el = 1;
        last_was_load = el;
      end else begin
        ef = cf; el = cl;
      end
    end
    exp_en = (ef && legal(fetch_addr)) || (el && legal(load_addr));
    exp_we = el && legal(load_addr);
    chk("fetch_gnt", {31'd0, fetch_gnt}, {31'd0, ef});
    chk("load_gnt", {31'd0, load_gnt}, {31'd0, el});
    chk("mem_en", {31'd0, mem_en}, {31'd0, exp_en});
    chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
    if (exp_en) chk("mem_addr", {24'd0, mem_addr}, (el ? load_addr : fetch_addr) / 4);
    if (exp_we) chk("mem_wdata", mem_wdata, load_wdata);
    if (ef) begin
      if (legal(fetch_addr)) fq.push_back('{err: 1'b0, data: ref_mem[fetch_addr / 4]});
      else fq.push_back('{err: 1'b1, data: NOP});
    end
    if (el) begin
      if (legal(load_addr)) ref_mem[load_addr / 4] = load_wdata;
      else lq.push_back(1'b1);
    end
`ifdef IMEM_ARB_STATS_EN
    chk("stall_cnt", {16'd0, stall_cnt}, m_stall);
    if (rst) m_stall = 0;
    else if (fetch_req && !ef && m_stall < 65535) m_stall++;
`else
    chk("stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
    if (rst) last_was_load = 1'b1;
    fg_seen = fetch_gnt;
    lg_seen = load_gnt;
  end

  // Monitor: response cycle after each grant, checked against the scoreboard
  initial begin
    rsp_t e;
    bit   le;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        chk("rst_rvalid", {31'd0, fetch_rvalid}, 32'd0);
        chk("rst_load_err", {31'd0, load_err}, 32'd0);
        fq.delete();
        lq.delete();
      end else begin
        if (fq.size() > 0) begin
          e = fq.pop_front();
          chk("fetch_rvalid", {31'd0, fetch_rvalid}, 32'd1);
          chk("fetch_rdata", fetch_rdata, e.data);
          chk("fetch_err", {31'd0, fetch_err}, {31'd0, e.err});
        end else begin
          chk("idle_rvalid", {31'd0, fetch_rvalid}, 32'd0);
        end
        le = (lq.size() > 0) ? lq.pop_front() : 1'b0;
        chk("load_err", {31'd0, load_err}, {31'd0, le});
      end
    end
  end

  task automatic cyc(input logic fr, input logic [31:0] fa, input logic lr,
                     input logic [31:0] la, input logic [31:0] lw,
                     input logic bh, input logic r);
    fetch_req = fr; fetch_addr = fa; load_req = lr; load_addr = la;
    load_wdata = lw; boot_hold = bh; rst = r;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom % 16;
    if (r == 0) return {22'd0, 8'($urandom % 16), 2'($urandom % 3 + 1)};
    if (r == 1) return 32'h400 + 4 * ($urandom % 64);
    return {22'd0, 8'($urandom % 16), 2'b00};
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end
    ram[0] = 32'h00A00093; ram[1] = 32'h01400113; ram[2] = 32'h002081B3;
    ram[4] = 32'hCAFE0004;
    for (int i = 0; i < 5; i++) ref_mem[i] = ram[i];
    rst = 1; boot_hold = 0; fetch_req = 0; load_req = 0;
    fetch_addr = 0; load_addr = 0; load_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    cyc(0, 0, 0, 0, 0, 0, 0);
    // Post-reset output state
    chk("reset_rvalid", {31'd0, fetch_rvalid}, 32'd0);
    chk("reset_ferr", {31'd0, fetch_err}, 32'd0);
    chk("reset_lerr", {31'd0, load_err}, 32'd0);
    chk("reset_rdata", fetch_rdata, 32'd0);
    chk("reset_stall", {16'd0, stall_cnt}, 32'd0);
    // Back-to-back fetches
    cyc(1, 32'h0, 0, 0, 0, 0, 0);
    cyc(1, 32'h4, 0, 0, 0, 0, 0);
    cyc(1, 32'h8, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    // Boot hold: loader only, fetch stalls
    cyc(1, 32'h0, 1, 32'h0C, 32'hDEADBEEF, 1, 0);
    repeat (3) cyc(1, 32'h0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    // Contention: fetch, load, fetch, load
    repeat (4) cyc(1, 32'h0C, 1, 32'h20, 32'h11112222, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    // Illegal fetches and load
    cyc(1, 32'h6, 0, 0, 0, 0, 0);
    cyc(1, 32'h400, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h401, 32'h55555555, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    // Same-address collision: fetch wins and sees old data, later fetch sees new
    cyc(1, 32'h10, 1, 32'h10, 32'h12345678, 0, 0);
    cyc(0, 0, 1, 32'h10, 32'h12345678, 0, 0);
    cyc(1, 32'h10, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    // Reset right after a fetch grant cancels the response
    cyc(1, 32'h4, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_rvalid", {31'd0, fetch_rvalid}, 32'd0);
    chk("post_rst_rdata", fetch_rdata, 32'd0);
    // Randomized traffic with held requests
    for (int c = 0; c < 3000; c++) begin
      if (!(fetch_req && !fg_seen)) begin
        fetch_req = ($urandom % 3) != 0;
        fetch_addr = rand_addr();
      end
      if (!(load_req && !lg_seen)) begin
        load_req = ($urandom % 3) == 0;
        load_addr = rand_addr();
        load_wdata = $urandom;
      end
      if ($urandom % 40 == 0) boot_hold = ~boot_hold;
      rst = ($urandom % 150) == 0;
      @(posedge clk); #1;
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
